pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with branch/jump redirect and circular return-address stack.
// One-cycle latency to pc/ras_count; stall holds all state unless jmp_en forces the update.
module pc_unit #(
    parameter int unsigned      WIDTH        = 64,
    parameter int unsigned      INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       br_en,
    input  logic [WIDTH-1:0]           br_offset,
    input  logic                       jmp_en,
    input  logic [WIDTH-1:0]           jmp_target,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           pc_next_seq,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_underflow
);

    localparam int unsigned     PW   = $clog2(RAS_DEPTH);
    localparam int unsigned     CW   = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_underflow;

    logic             w_taken;
    logic             w_nonempty;
    logic             w_pop;
    logic             w_push;
    logic             w_underflow;
    logic [PW-1:0]    w_top_ptr;
    logic [PW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_br;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_pc_nxt;

    assign w_taken     = jmp_en | ~stall;
    assign w_nonempty  = (r_count != '0);
    assign w_pop       = w_taken & ret & w_nonempty;
    assign w_push      = w_taken & call;
    assign w_underflow = w_taken & ret & ~w_nonempty;

    // r_wr_ptr is the next free slot; the top of stack sits just below it.
    assign w_top_ptr = r_wr_ptr - PW'(1);
    assign w_top     = r_ras[w_top_ptr];

    // A same-cycle pop+push reuses the popped slot instead of advancing.
    assign w_wr_idx  = w_pop ? w_top_ptr : r_wr_ptr;

    assign w_seq = r_pc + WIDTH'(INC);
    assign w_br  = r_pc + br_offset;

    always_comb begin
        w_pc_nxt = w_seq;
        if (jmp_en) begin
            w_pc_nxt = jmp_target;
        end else if (w_pop) begin
            w_pc_nxt = w_top;
        end else if (br_en) begin
            w_pc_nxt = w_br;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= w_underflow;
            if (w_taken) begin
                r_pc <= w_pc_nxt;
            end
            // Pushing into a full stack overwrites the oldest entry, so count saturates.
            if (w_push && !w_pop) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (r_count != FULL) begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_pop && !w_push) begin
                r_wr_ptr <= w_top_ptr;
                r_count  <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_ras[w_wr_idx] <= w_seq;
        end
    end

    assign pc            = r_pc;
    assign pc_next_seq   = w_seq;
    assign ras_count     = r_count;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue-based reference model checked every cycle.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_en;
    logic [63:0] br_offset;
    logic        jmp_en;
    logic [63:0] jmp_target;
    logic        call;
    logic        ret;
    logic [63:0] pc;
    logic [63:0] pc_next_seq;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    pc_unit #(
        .WIDTH(64), .INC(4), .RESET_VECTOR(64'h0), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_en(br_en),
        .br_offset(br_offset), .jmp_en(jmp_en), .jmp_target(jmp_target),
        .call(call), .ret(ret), .pc(pc), .pc_next_seq(pc_next_seq),
        .ras_count(ras_count), .ras_underflow(ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural PC plus a return stack kept as a bounded queue.
    logic [63:0] m_pc;
    logic [63:0] ras_q[$];
    bit          m_uf;

    always @(posedge clk) begin : model
        logic [63:0] seq, npc, top;
        bit          have;
        if (reset) begin
            m_pc = 64'h0;
            ras_q.delete();
            m_uf = 0;
        end else begin
            m_uf = 0;
            if (jmp_en || !stall) begin
                seq  = m_pc + 64'd4;
                have = ras_q.size() > 0;
                top  = 64'h0;
                if (ret && have) top = ras_q.pop_back();
                if (ret && !have) m_uf = 1;
                if (jmp_en)            npc = jmp_target;
                else if (ret && have)  npc = top;
                else if (br_en)        npc = m_pc + br_offset;
                else                   npc = seq;
                if (call) begin
                    ras_q.push_back(seq);
                    if (ras_q.size() > 4) void'(ras_q.pop_front());
                end
                m_pc = npc;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                       input logic [63:0] exp);
        check(name, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_next_seq", pc_next_seq, m_pc + 64'd4);
            check("ras_count", 64'(ras_count), 64'(ras_q.size()));
            check("ras_underflow", 64'(ras_underflow), 64'(m_uf));
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        reset = 0; stall = 0; br_en = 0; br_offset = '0;
        jmp_en = 0; jmp_target = '0; call = 0; ret = 0;
    endtask

    task automatic jump(input logic [63:0] tgt, input logic c, input logic r);
        idle();
        jmp_en = 1; jmp_target = tgt; call = c; ret = r;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        stall = 1; jmp_en = 1; jmp_target = 64'h500; call = 1;
        tick();
        chk_en = 1;
        pin("rst_pc", pc, m_pc, 64'h0);
        check("rst_cnt", 64'(ras_count), 64'h0);
        check("rst_uf", 64'(ras_underflow), 64'h0);
        idle();

        // Sequential fetch after reset
        for (int i = 1; i <= 3; i++) begin
            tick();
            pin("seq_pc", pc, m_pc, 64'(4 * i));
        end

        // Backward branch, then stalled branch is ignored
        jump(64'h100, 0, 0);
        br_en = 1; br_offset = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        pin("br_pc", pc, m_pc, 64'hF8);
        stall = 1;
        tick();
        pin("stall_br_pc", pc, m_pc, 64'hF8);
        idle();

        // Call through absolute jump, then return
        jump(64'h200, 0, 0);
        jump(64'h1000, 1, 0);
        pin("call_pc", pc, m_pc, 64'h1000);
        check("call_cnt", 64'(ras_count), 64'h1);
        ret = 1;
        tick();
        pin("ret_pc", pc, m_pc, 64'h204);
        check("ret_cnt", 64'(ras_count), 64'h0);
        idle();

        // Overflow: five nested calls keep the newest four
        jump(64'h10, 0, 0);
        for (int i = 2; i <= 6; i++) jump(64'(16 * i), 1, 0);
        jump(64'h80, 0, 0);
        check("full_cnt", 64'(ras_count), 64'h4);
        ret = 1;
        for (int i = 5; i >= 2; i--) begin
            tick();
            pin("pop_pc", pc, m_pc, 64'(16 * i + 4));
        end
        tick();
        pin("uf_pc", pc, m_pc, 64'h28);
        check("uf_pulse", 64'(ras_underflow), 64'h1);
        idle();
        tick();
        check("uf_clear", 64'(ras_underflow), 64'h0);

        // Stalled call is ignored
        stall = 1; call = 1;
        tick();
        check("stall_call_cnt", 64'(ras_count), 64'h0);
        idle();

        // Call+ret on empty stack underflows but still pushes
        call = 1; ret = 1;
        tick();
        pin("cr_empty_pc", pc, m_pc, 64'h30);
        check("cr_empty_cnt", 64'(ras_count), 64'h1);
        check("cr_empty_uf", 64'(ras_underflow), 64'h1);
        // Call+ret on non-empty stack swaps the top in place
        tick();
        pin("cr_pc", pc, m_pc, 64'h30);
        check("cr_cnt", 64'(ras_count), 64'h1);
        idle();
        ret = 1;
        tick();
        pin("cr_ret_pc", pc, m_pc, 64'h34);
        idle();

        // Address wrap and jump overriding stall
        jump(64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        check("wrap_seq", pc_next_seq, 64'h0);
        tick();
        pin("wrap_pc", pc, m_pc, 64'h0);
        stall = 1; jmp_en = 1; jmp_target = 64'h40;
        tick();
        pin("stall_jmp_pc", pc, m_pc, 64'h40);
        idle();

        // Reset during a stall with a populated stack
        call = 1;
        tick();
        tick();
        check("two_cnt", 64'(ras_count), 64'h2);
        idle();
        stall = 1; ret = 1;
        tick();
        pin("stall_ret_pc", pc, m_pc, 64'h48);
        check("stall_ret_cnt", 64'(ras_count), 64'h2);
        reset = 1;
        tick();
        pin("mid_rst_pc", pc, m_pc, 64'h0);
        check("mid_rst_cnt", 64'(ras_count), 64'h0);
        idle();
        ret = 1;
        tick();
        pin("post_rst_pc", pc, m_pc, 64'h4);
        check("post_rst_uf", 64'(ras_underflow), 64'h1);
        idle();
        tick();

        chk_en = 0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
